// File: rtl/shop_pkg.sv
// Shared constants for the shop_v command datapath and its terminal arbiter:
// ASCII word widths, the prompt strings, and the arbiter state encoding.
package shop_pkg;

  localparam int I_A_NUM_CHARS = 7;
  localparam int O_A_NUM_CHARS = 9;
  localparam int I_A_CHAR_BITS = I_A_NUM_CHARS * 8;
  localparam int O_A_CHAR_BITS = O_A_NUM_CHARS * 8;

  // Strings are right-aligned and zero-padded on the left to the full output word.
  localparam logic [O_A_CHAR_BITS-1:0] OUT_STR__ASK_CMD = {{(O_A_NUM_CHARS-4){8'h00}}, "Cmd?"};
  localparam logic [O_A_CHAR_BITS-1:0] OUT_STR__WAIT    = {{(O_A_NUM_CHARS-4){8'h00}}, "Wait"};

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_SESSION = 2'd1;
  localparam logic [1:0] ARB_ABORT   = 2'd2;

endpackage

// File: rtl/shop_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping modulo N_TERMS. Grant is one-hot; valid flags any request.
module shop_rr_pick #(
  parameter int N_TERMS = 4,
  parameter int PTR_W   = 2
) (
  input  logic [N_TERMS-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [N_TERMS-1:0] grant,
  output logic               valid
);

  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_TERMS; i++) begin
      idx = (int'(pointer) + i) % N_TERMS;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shop_term_arbiter.sv
// Shares one shop_v datapath between N_TERMS terminals with round-robin sessions,
// aborting stuck sessions via the shop reset. Optional stats: SHOP_ARB_STATS_EN.
module shop_term_arbiter
  import shop_pkg::*;
#(
  parameter int N_TERMS        = 4,
  parameter int I_A_NUM_BITS   = I_A_CHAR_BITS,
  parameter int O_A_NUM_BITS   = O_A_CHAR_BITS,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ABORT_CYCLES   = 2
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [N_TERMS-1:0]               i_req,
  input  logic [N_TERMS-1:0]               i_rel,
  input  logic [N_TERMS-1:0]               i_rdy,
  input  logic [N_TERMS*I_A_NUM_BITS-1:0]  i_a,
  input  logic [O_A_NUM_BITS-1:0]          i_shop_a,
  output logic [N_TERMS-1:0]               o_gnt,
  output logic                             o_shop_rdy,
  output logic [I_A_NUM_BITS-1:0]          o_shop_a,
  output logic                             o_shop_reset,
  output logic [N_TERMS*O_A_NUM_BITS-1:0]  o_a
`ifdef SHOP_ARB_STATS_EN
  ,
  output logic [7:0]                       o_abort_cnt,
  output logic [N_TERMS*8-1:0]             o_grant_cnt
`endif
);

  localparam int PTR_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int ABT_W = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  localparam logic [O_A_NUM_BITS-1:0] ASK_CMD  = O_A_NUM_BITS'(OUT_STR__ASK_CMD);
  localparam logic [O_A_NUM_BITS-1:0] WAIT_STR = O_A_NUM_BITS'(OUT_STR__WAIT);

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [N_TERMS-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < N_TERMS; i++)
      if (oh[i]) onehot_idx = PTR_W'(i);
  endfunction

  logic [1:0]         state;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   tcnt;
  logic [ABT_W-1:0]   acnt;
  logic [N_TERMS-1:0] pick_gnt;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;

  shop_rr_pick #(
    .N_TERMS (N_TERMS),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (i_req),
    .pointer (ptr),
    .grant   (pick_gnt),
    .valid   (pick_vld)
  );

  assign pick_idx = onehot_idx(pick_gnt);

  logic in_session, g_rdy, end_cond, at_ask, tmo, abort_entry, grant_entry;

  assign in_session  = (state == ARB_SESSION);
  assign g_rdy       = i_rdy[gidx];
  assign end_cond    = i_rel[gidx] | ~i_req[gidx];
  assign at_ask      = (i_shop_a == ASK_CMD);
  assign tmo         = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // A release at the prompt wins over a coincident timeout.
  assign abort_entry = in_session & ((end_cond & ~at_ask) | (~end_cond & tmo));
  assign grant_entry = (state == ARB_IDLE) & pick_vld;

  assign o_shop_a   = in_session ? i_a[int'(gidx)*I_A_NUM_BITS +: I_A_NUM_BITS] : '0;
  assign o_shop_rdy = in_session & g_rdy;

  for (genvar t = 0; t < N_TERMS; t++) begin : g_out
    assign o_a[t*O_A_NUM_BITS +: O_A_NUM_BITS] =
      (in_session && gidx == PTR_W'(t)) ? i_shop_a : WAIT_STR;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ARB_ABORT;
      o_gnt        <= '0;
      gidx         <= '0;
      ptr          <= '0;
      tcnt         <= '0;
      acnt         <= '0;
      o_shop_reset <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            state <= ARB_SESSION;
            o_gnt <= pick_gnt;
            gidx  <= pick_idx;
            ptr   <= PTR_W'((int'(pick_idx) + 1) % N_TERMS);
            tcnt  <= '0;
          end
        end
        ARB_SESSION: begin
          tcnt <= (g_rdy || tmo) ? '0 : tcnt + 1'b1;
          if (abort_entry) begin
            state        <= ARB_ABORT;
            o_gnt        <= '0;
            o_shop_reset <= 1'b1;
            acnt         <= '0;
          end else if (end_cond) begin
            state <= ARB_IDLE;
            o_gnt <= '0;
          end
        end
        default: begin
          if (acnt == ABT_W'(ABORT_CYCLES - 1)) begin
            state        <= ARB_IDLE;
            o_shop_reset <= 1'b0;
          end else begin
            acnt <= acnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef SHOP_ARB_STATS_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_abort_cnt <= '0;
      o_grant_cnt <= '0;
    end else begin
      if (abort_entry) o_abort_cnt <= sat_inc(o_abort_cnt);
      if (grant_entry)
        o_grant_cnt[int'(pick_idx)*8 +: 8] <= sat_inc(o_grant_cnt[int'(pick_idx)*8 +: 8]);
    end
  end
`endif

endmodule

// File: tb/tb_shop_term_arbiter.sv
// Self-checking bench for shop_term_arbiter: directed vector table, hand-written
// corner sequences, then randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_shop_term_arbiter;

  localparam int N   = 4;
  localparam int IA  = 56;
  localparam int OA  = 72;
  localparam int TMO = 64;
  localparam int ABT = 2;

  localparam logic [OA-1:0] ASK    = {40'h0, "Cmd?"};
  localparam logic [OA-1:0] WAITS  = {40'h0, "Wait"};
  localparam logic [OA-1:0] USRN   = {8'h0, "Usrname?"};
  localparam logic [IA-1:0] LOGIN  = {16'h0, "Login"};
  localparam logic [IA-1:0] ADDUSR = {8'h0, "AddUsr"};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0, rel = '0, rdy = '0;
  logic [N*IA-1:0] ia = '0;
  logic [OA-1:0]   shop_a = '0;
  logic [N-1:0]    gnt;
  logic            srdy, sreset;
  logic [IA-1:0]   sa;
  logic [N*OA-1:0] oa;
`ifdef SHOP_ARB_STATS_EN
  logic [7:0]      abort_cnt;
  logic [N*8-1:0]  grant_cnt;
`endif

  always #5 clk = ~clk;

  shop_term_arbiter #(
    .N_TERMS(N), .I_A_NUM_BITS(IA), .O_A_NUM_BITS(OA),
    .TIMEOUT_CYCLES(TMO), .ABORT_CYCLES(ABT)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_rel(rel), .i_rdy(rdy),
    .i_a(ia), .i_shop_a(shop_a), .o_gnt(gnt), .o_shop_rdy(srdy),
    .o_shop_a(sa), .o_shop_reset(sreset), .o_a(oa)
`ifdef SHOP_ARB_STATS_EN
    , .o_abort_cnt(abort_cnt), .o_grant_cnt(grant_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 session, 2 abort.
  int m_mode, m_g, m_ptr, m_idle, m_left, m_abort_cnt;
  int m_gcnt[N];

  task automatic m_reset();
    m_mode = 2; m_left = ABT; m_g = 0; m_ptr = 0; m_idle = 0; m_abort_cnt = 0;
    for (int i = 0; i < N; i++) m_gcnt[i] = 0;
  endtask

  task automatic m_clock();
    int w;
    bit ends;
    case (m_mode)
      0: begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        if (w >= 0) begin
          m_mode = 1; m_g = w; m_ptr = (w + 1) % N; m_idle = 0;
          if (m_gcnt[w] < 255) m_gcnt[w]++;
        end
      end
      1: begin
        ends = rel[m_g] || !req[m_g];
        if (ends && shop_a == ASK) m_mode = 0;
        else if (ends || m_idle == TMO - 1) begin
          m_mode = 2; m_left = ABT;
          if (m_abort_cnt < 255) m_abort_cnt++;
        end
        m_idle = rdy[m_g] ? 0 : m_idle + 1;
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_model(input string nm);
    logic [N-1:0] eg;
    eg = (m_mode == 1) ? N'(1 << m_g) : '0;
    chk({nm, ".gnt"}, gnt, eg);
    chk({nm, ".shop_reset"}, sreset, m_mode == 2);
    chk({nm, ".shop_rdy"}, srdy, (m_mode == 1) && rdy[m_g]);
    chk({nm, ".shop_a"}, sa, (m_mode == 1) ? ia[m_g*IA +: IA] : '0);
    for (int t = 0; t < N; t++)
      chk({nm, ".o_a"}, oa[t*OA +: OA], (m_mode == 1 && t == m_g) ? shop_a : WAITS);
`ifdef SHOP_ARB_STATS_EN
    chk({nm, ".abort_cnt"}, abort_cnt, m_abort_cnt);
    for (int t = 0; t < N; t++) chk({nm, ".grant_cnt"}, grant_cnt[t*8 +: 8], m_gcnt[t]);
`endif
  endtask

  // Advance to just after the next rising edge, keeping the model in step.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset(); else m_clock();
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  typedef struct packed {
    logic [3:0] req, rel, rdy, e_gnt;
    logic       e_sr, e_srdy;
  } vec_t;
  vec_t tv[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tv[1]  = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
    tv[2]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tv[3]  = '{4'hF, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1};
    tv[4]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tv[5]  = '{4'hF, 4'h2, 4'h2, 4'h2, 1'b0, 1'b1};
    tv[6]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tv[7]  = '{4'hF, 4'h4, 4'h4, 4'h4, 1'b0, 1'b1};
    tv[8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tv[9]  = '{4'hF, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1};
    tv[10] = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    tv[11] = '{4'hF, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1};
    tv[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

    shop_a = ASK;
    m_reset();
    repeat (3) tick();
    mid();
    chk("reset.gnt", gnt, 4'h0);
    chk("reset.shop_reset", sreset, 1'b1);
    chk("reset.shop_rdy", srdy, 1'b0);
    chk("reset.shop_a", sa, '0);
    for (int t = 0; t < N; t++) chk("reset.o_a", oa[t*OA +: OA], WAITS);
    tick();
    rst_n = 1'b1;

    // Reset-release pulse and fair rotation with clean releases.
    for (int t = 0; t < N; t++) ia[t*IA +: IA] = LOGIN;
    for (int i = 0; i < 13; i++) begin
      req = tv[i].req; rel = tv[i].rel; rdy = tv[i].rdy;
      mid();
      chk($sformatf("vec%0d.gnt", i), gnt, tv[i].e_gnt);
      chk($sformatf("vec%0d.shop_reset", i), sreset, tv[i].e_sr);
      chk($sformatf("vec%0d.shop_rdy", i), srdy, tv[i].e_srdy);
      chk($sformatf("vec%0d.shop_a", i), sa, (tv[i].e_gnt != 0) ? LOGIN : '0);
      for (int t = 0; t < N; t++)
        chk($sformatf("vec%0d.o_a%0d", i, t), oa[t*OA +: OA], tv[i].e_gnt[t] ? ASK : WAITS);
      tick();
    end
`ifdef SHOP_ARB_STATS_EN
    chk("stats.grant0", grant_cnt[7:0], 8'd2);
    chk("stats.grant3", grant_cnt[31:24], 8'd1);
    chk("stats.abort0", abort_cnt, 8'd0);
`endif

    // Granted t2 muxes its word; t0's concurrent rdy is ignored.
    req = 4'b0100; tick();
    ia[2*IA +: IA] = ADDUSR; rdy = 4'b0101; shop_a = USRN;
    mid();
    chk("mux.gnt", gnt, 4'b0100);
    chk("mux.shop_a", sa, ADDUSR);
    chk("mux.shop_rdy", srdy, 1'b1);
    chk("mux.o_a0", oa[0 +: OA], WAITS);
    chk("mux.o_a2", oa[2*OA +: OA], USRN);
    tick();
    rdy = 4'b0001; shop_a = ASK; rel = 4'b0100;
    mid();
    chk("mux.nongrant_rdy", srdy, 1'b0);
    tick();
    rel = '0; req = '0;
    mid();
    chk("mux.release_gnt", gnt, 4'h0);
    chk("mux.release_reset", sreset, 1'b0);
    tick();

    // Idle session times out after TMO cycles.
    rdy = '0; req = 4'b1000; tick();
    for (int k = 0; k < TMO; k++) begin
      mid();
      chk($sformatf("tmo.k%0d.gnt", k), gnt, 4'b1000);
      chk($sformatf("tmo.k%0d.reset", k), sreset, 1'b0);
      tick();
    end
    req = '0;
    mid(); chk("tmo.abort1.gnt", gnt, 4'h0); chk("tmo.abort1.reset", sreset, 1'b1); tick();
    mid(); chk("tmo.abort2.reset", sreset, 1'b1); tick();
    mid(); chk("tmo.abort_end.reset", sreset, 1'b0);
`ifdef SHOP_ARB_STATS_EN
    chk("tmo.abort_cnt", abort_cnt, 8'd1);
`endif
    tick();

    // Request dropped mid-command aborts.
    req = 4'b0001; tick();
    shop_a = USRN; req = '0;
    mid(); chk("drop_busy.gnt", gnt, 4'b0001); tick();
    shop_a = ASK;
    mid(); chk("drop_busy.reset1", sreset, 1'b1); chk("drop_busy.gnt_off", gnt, 4'h0); tick();
    mid(); chk("drop_busy.reset2", sreset, 1'b1); tick();
    mid(); chk("drop_busy.reset_end", sreset, 1'b0);
`ifdef SHOP_ARB_STATS_EN
    chk("drop_busy.abort_cnt", abort_cnt, 8'd2);
`endif
    tick();

    // Request dropped at the prompt ends cleanly.
    req = 4'b0001; tick();
    req = '0;
    mid(); chk("drop_ask.gnt", gnt, 4'b0001); tick();
    mid(); chk("drop_ask.gnt_off", gnt, 4'h0); chk("drop_ask.reset", sreset, 1'b0); tick();
    mid(); chk("drop_ask.reset_next", sreset, 1'b0); tick();

    // Release coincident with timeout at the prompt: clean end.
    req = 4'b0010; tick();
    for (int k = 0; k < TMO - 1; k++) tick();
    rel = 4'b0010;
    mid(); chk("rel_tmo.gnt", gnt, 4'b0010); tick();
    rel = '0; req = '0;
    mid(); chk("rel_tmo.gnt_off", gnt, 4'h0); chk("rel_tmo.reset", sreset, 1'b0); tick();
    mid(); chk("rel_tmo.reset_next", sreset, 1'b0);
`ifdef SHOP_ARB_STATS_EN
    chk("rel_tmo.abort_cnt", abort_cnt, 8'd2);
`endif
    tick();

    // Randomized traffic against the model.
    begin
      bit quiet = 1'b0;
      for (int c = 0; c < 2500; c++) begin
        if (c % 200 == 0) quiet = ($urandom_range(0, 2) == 0);
        if (!quiet)
          for (int t = 0; t < N; t++)
            if ($urandom_range(0, 15) == 0) req[t] = ~req[t];
        rel = (!quiet && $urandom_range(0, 15) == 0) ? N'($urandom) : '0;
        rdy = quiet ? '0 : (N'($urandom) & N'($urandom));
        for (int t = 0; t < N; t++) ia[t*IA +: IA] = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0, 1:    shop_a = ASK;
          2:       shop_a = USRN;
          default: shop_a = {$urandom, $urandom, $urandom};
        endcase
        mid();
        check_model("rand");
        tick();
      end
    end

    // Asynchronous reset in the middle of a session.
    req = 4'b0001; rel = '0; rdy = '0; shop_a = ASK;
    begin
      int w = 0;
      while (m_mode != 1 && w < 20) begin tick(); w++; end
    end
    #2;
    chk("async.in_session_gnt", gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("async.gnt", gnt, 4'h0);
    chk("async.shop_reset", sreset, 1'b1);
    chk("async.shop_rdy", srdy, 1'b0);
    for (int t = 0; t < N; t++) chk("async.o_a", oa[t*OA +: OA], WAITS);
    m_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mid();
      check_model("post_reset");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shop_term_arbiter.md
Name: shop_term_arbiter

Overview:
- Shares one shop_v command datapath between N_TERMS user terminals.
- Grants exclusive sessions round-robin and muxes the granted terminal's i_a/i_rdy into the shop.
- Routes shop output back to the granted terminal only.
- Aborts stalled or abandoned sessions by pulsing the shop's active-high reset, so the shop FSM never stays stuck mid-command.

Parameters:
- N_TERMS, 4, number of requesting terminals (2..8).
- I_A_NUM_BITS, 56, terminal/shop input word width (7 ASCII chars).
- O_A_NUM_BITS, 72, shop output word width (9 ASCII chars).
- TIMEOUT_CYCLES, 64, idle cycles inside a session before abort (>=2).
- ABORT_CYCLES, 2, width of the o_shop_reset pulse in cycles (>=1).
- OUT_STR__ASK_CMD, "Cmd?", shop idle prompt; a session may end cleanly only while the shop shows this string.
- OUT_STR__WAIT, "Wait", string shown to non-granted terminals.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_req  in  N_TERMS  per-terminal session request (level).
- i_rel  in  N_TERMS  per-terminal release strobe (1 cycle).
- i_rdy  in  N_TERMS  per-terminal word-valid.
- i_a  in  N_TERMS*I_A_NUM_BITS  per-terminal word; terminal t occupies slice [t*I_A_NUM_BITS +: I_A_NUM_BITS].
- i_shop_a  in  O_A_NUM_BITS  shop o_a.
- o_gnt  out  N_TERMS  one-hot grant, registered.
- o_shop_rdy  out  1  to shop i_rdy.
- o_shop_a  out  I_A_NUM_BITS  to shop i_a.
- o_shop_reset  out  1  to shop i_reset, active high, registered.
- o_a  out  N_TERMS*O_A_NUM_BITS  per-terminal output, same slicing as i_a.

Behaviour:
- Reset (asynchronous, while i_reset_n=0):
  - state=ABORT; o_gnt=0; rr pointer=0; timeout count=0.
  - o_shop_reset=1; o_shop_rdy=0; o_shop_a=0; all o_a=OUT_STR__WAIT.
  - After deassertion, ABORT runs a full ABORT_CYCLES pulse, then IDLE. This guarantees the shop is always initialised.
- States: IDLE, SESSION, ABORT.
- IDLE:
  - o_gnt=0, o_shop_rdy=0.
  - If any i_req bit is set, pick the first set bit searching from the rr pointer upward, wrapping modulo N_TERMS.
  - At that edge: o_gnt is registered one-hot, the pointer is set to winner+1 mod N_TERMS, the count is cleared, and the state moves to SESSION.
  - Grant latency is 1 cycle from the first i_req sample.
- SESSION (granted terminal g):
  - o_shop_a=i_a[g] and o_shop_rdy=i_rdy[g], combinational (zero latency).
  - o_a[g]=i_shop_a; every other o_a=OUT_STR__WAIT.
  - i_rdy/i_a from non-granted terminals are ignored.
  - Timeout count clears on any cycle with i_rdy[g]=1, otherwise increments.
  - End condition E = i_rel[g]=1 or i_req[g]=0.
  - E with i_shop_a==OUT_STR__ASK_CMD: state goes to IDLE, o_gnt clears.
  - E with any other i_shop_a: state goes to ABORT (command left half-done).
  - No E and count == TIMEOUT_CYCLES-1: state goes to ABORT.
  - E and timeout in the same cycle: E wins (clean release if the shop is at "Cmd?").
  - i_rel on a non-granted bit is ignored.
- ABORT:
  - o_gnt=0; o_shop_rdy=0; o_shop_reset=1 for exactly ABORT_CYCLES cycles (internal counter); then IDLE.
  - Requests arriving during ABORT are held pending; they are served in IDLE with the rr pointer unchanged.
- Fairness: with all i_req high and each session released cleanly, grants cycle 0,1,2,3,0...
- Timeout counter width is clog2(TIMEOUT_CYCLES); it never wraps, because the abort fires first.

Optional Feature:
- SHOP_ARB_STATS_EN.
- Defined: adds output o_abort_cnt [7:0], counting ABORT entries caused by timeout or unclean release.
- Also adds output o_grant_cnt [N_TERMS*8-1:0], per-terminal grant counts.
- Both saturate at 255 and clear only on reset; the reset-entry ABORT is not counted.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- shop_pkg holds:
  - the ASCII width constants (I_A/O_A char counts);
  - the OUT_STR__ASK_CMD and OUT_STR__WAIT strings;
  - the arbiter state encoding (ARB_IDLE, ARB_SESSION, ARB_ABORT).
- shop_v later imports the same strings from shop_pkg.
- One sub-module: shop_rr_pick, a combinational round-robin picker with inputs req and pointer and outputs one-hot grant and valid.

Test Plan:
- Reset release → o_shop_reset high exactly 2 cycles after i_reset_n rises, o_gnt=0, all o_a="Wait", then IDLE.
- i_req=4'b1111, each session sends "Login", releases with i_shop_a="Cmd?" → o_gnt sequence 0001,0010,0100,1000,0001, each 1 cycle after IDLE.
- Granted t=2 sends i_a[2]="AddUsr" with i_rdy[2]=1; t=0 drives i_rdy[0]=1 simultaneously → o_shop_a="AddUsr", o_shop_rdy=1, o_a[0]="Wait".
- Granted terminal idle 64 cycles → ABORT at cycle 63, o_shop_reset pulse of 2 cycles; with SHOP_ARB_STATS_EN, o_abort_cnt=1.
- Granted terminal drops i_req while i_shop_a="Usrname?" → ABORT; the same drop while i_shop_a="Cmd?" → IDLE with no reset pulse.
- i_rel[g] coincident with timeout while i_shop_a="Cmd?" → IDLE, no abort; i_reset_n low mid-SESSION → o_gnt=0 and o_shop_reset=1 asynchronously.
